// File: rtl/fxfl_pkg.sv
// Shared widths and FSM state encoding for the fixed-to-float converter slice.
package fxfl_pkg;

    localparam int FIXED_W  = 22;
    localparam int FRAC_W   = 20;
    localparam int FLOAT_W  = 32;
    localparam int EXP_BIAS = 127;
    localparam int MANT_W   = 23;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        HOLD
    } state_t;

endpackage

// File: rtl/fixed_to_float_norm.sv
// Combinational normalizer: 22-bit sign-magnitude fixed point (1.20) to IEEE-754 single.
module fixed_to_float_norm
    import fxfl_pkg::*;
(
    input  logic [FIXED_W-1:0] fixed_in,
    output logic [FLOAT_W-1:0] float_out
);

    logic [FRAC_W:0]  mag;
    logic [4:0]       lead;
    logic [MANT_W:0]  aligned;
    logic [7:0]       exponent;

    assign mag = fixed_in[FRAC_W:0];

    always_comb begin
        lead = '0;
        for (int i = 0; i <= FRAC_W; i++) begin
            if (mag[i]) begin
                lead = 5'(i);
            end
        end
    end

    // Shift the leading one up to bit MANT_W; the hidden bit then drops out of the mantissa field.
    assign aligned  = {3'b000, mag} << (5'(MANT_W) - lead);
    assign exponent = 8'(EXP_BIAS - FRAC_W) + {3'b000, lead};

    // A zero magnitude maps to +0 regardless of the sign bit.
    assign float_out = (mag == '0) ? '0
                                   : {fixed_in[FIXED_W-1], exponent, aligned[MANT_W-1:0]};

endmodule

// File: rtl/fixed_to_float_arbiter.sv
// Round-robin arbiter sharing one fixed-to-float normalizer among N_REQ requesters.
module fixed_to_float_arbiter
    import fxfl_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int TAG_W = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [FIXED_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FLOAT_W-1:0]       out_result,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     busy
);

    state_t              state;
    state_t              state_next;
    logic [TAG_W-1:0]    rr_ptr;
    logic [TAG_W-1:0]    rr_next;
    logic [TAG_W-1:0]    grant;
    logic [TAG_W-1:0]    tag_q;
    logic [TAG_W:0]      cand_sum;
    logic [TAG_W-1:0]    cand;
    logic [FIXED_W-1:0]  operand_q;
    logic [FLOAT_W-1:0]  norm_result;
    logic                accept;

    // Scan from the farthest candidate back to rr_ptr so the nearest valid requester wins.
    always_comb begin
        grant    = '0;
        cand_sum = '0;
        cand     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand_sum = {1'b0, rr_ptr} + (TAG_W+1)'(k);
            if (cand_sum >= (TAG_W+1)'(N_REQ)) begin
                cand_sum = cand_sum - (TAG_W+1)'(N_REQ);
            end
            cand = cand_sum[TAG_W-1:0];
            if (req_valid[cand]) begin
                grant = cand;
            end
        end
    end

    assign req_ready = (rst_n && (state == IDLE) && (|req_valid))
                     ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant)
                     : '0;
    assign accept    = |(req_valid & req_ready);
    assign rr_next   = (grant == TAG_W'(N_REQ - 1)) ? '0 : grant + TAG_W'(1);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = CONV;
            CONV:                   state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    fixed_to_float_norm u_norm (
        .fixed_in  (operand_q),
        .float_out (norm_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            operand_q  <= '0;
            tag_q      <= '0;
            out_result <= '0;
            out_tag    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                operand_q <= req_data[grant*FIXED_W +: FIXED_W];
                tag_q     <= grant;
                rr_ptr    <= rr_next;
            end
            if (state == CONV) begin
                out_result <= norm_result;
                out_tag    <= tag_q;
            end
        end
    end

endmodule

// File: tb/tb_fixed_to_float_arbiter.sv
// Scoreboard bench for fixed_to_float_arbiter: directed values, round-robin, backpressure, reset, soak.
module tb_fixed_to_float_arbiter;

    localparam int N      = 4;
    localparam int TW     = 2;
    localparam int M_IDLE = 0;
    localparam int M_CONV = 1;
    localparam int M_HOLD = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [22*N-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_result;
    logic [TW-1:0]   out_tag;
    logic            busy;

    fixed_to_float_arbiter #(.N_REQ(N), .TAG_W(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int              n_cmp      = 0;
    int              n_bad      = 0;
    int              n_sent     = 0;
    int              n_recv     = 0;
    int              n_discard  = 0;
    int              m_state    = M_IDLE;
    logic [TW-1:0]   m_rr       = '0;
    logic [N-1:0]    acc_mask   = '0;
    int              ready_mode = 0;
    logic            ready_val  = 1'b1;
    logic [31:0]     last_result;
    logic [TW-1:0]   last_tag;
    logic [21:0]     pend [N][$];
    logic [TW+31:0]  sb [$];
    logic [TW-1:0]   otags [$];
    logic [TW-1:0]   g;
    logic [N-1:0]    exp_rdy;
    logic [TW+31:0]  head;

    logic [21:0] vin  [8] = '{22'h100000, 22'h080000, 22'h300000, 22'h000001,
                              22'h200000, 22'h1FFFFF, 22'h0C0000, 22'h3C0000};
    logic [31:0] vexp [8] = '{32'h3F80_0000, 32'h3F00_0000, 32'hBF80_0000, 32'h3580_0000,
                              32'h0000_0000, 32'h3FFF_FFF8, 32'h3F40_0000, 32'hBFE0_0000};

    // Reference conversion by repeated left-normalisation.
    function automatic logic [31:0] refFloat(input logic [21:0] w);
        logic [20:0] mm;
        int e;
        mm = w[20:0];
        if (mm == '0) return 32'h0;
        e = 127;
        while (!mm[20]) begin
            mm = mm << 1;
            e--;
        end
        return {w[21], 8'(e), mm[19:0], 3'b000};
    endfunction

    function automatic logic [TW-1:0] refGrant(input logic [N-1:0] v, input logic [TW-1:0] ptr);
        logic [TW-1:0] c;
        for (int k = 0; k < N; k++) begin
            c = TW'((int'(ptr) + k) % N);
            if (v[c]) return c;
        end
        return '0;
    endfunction

    function automatic bit pendEmpty();
        for (int i = 0; i < N; i++) begin
            if (pend[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [21:0] d);
        pend[idx].push_back(d);
        n_sent++;
    endtask

    task automatic waitIdle(input int budget);
        int cnt = 0;
        bit done = 1'b0;
        while (!done && cnt < budget) begin
            @(negedge clk);
            #1;
            cnt++;
            done = (m_state == M_IDLE) && (sb.size() == 0) && pendEmpty();
        end
        checkOutput("drain", 64'(done), 64'(1));
    endtask

    task automatic waitHold(input int budget);
        int cnt = 0;
        bit done = 1'b0;
        while (!done && cnt < budget) begin
            @(negedge clk);
            #1;
            cnt++;
            done = (m_state == M_HOLD);
        end
        checkOutput("hold_reach", 64'(done), 64'(1));
    endtask

    function automatic logic [21:0] randWord();
        logic [21:0] w;
        w = 22'($urandom);
        w[20:0] = w[20:0] >> $urandom_range(20);
        if ($urandom_range(7) == 0) w[20:0] = '0;
        return w;
    endfunction

    // Requester and sink drivers: present queue heads, retire them after a modelled transfer.
    initial begin
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc_mask[i] && pend[i].size() > 0) pend[i].delete(0);
                if (pend[i].size() > 0) begin
                    req_data[i*22 +: 22] = pend[i][0];
                    req_valid[i] = (ready_mode == 0) || ($urandom_range(3) != 0);
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            out_ready = (ready_mode != 0) ? 1'($urandom_range(1)) : ready_val;
        end
    end

    // Cycle model of the arbiter, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("rst_valid",  64'(out_valid),  64'(0));
            checkOutput("rst_ready",  64'(req_ready),  64'(0));
            checkOutput("rst_busy",   64'(busy),       64'(0));
            checkOutput("rst_result", 64'(out_result), 64'(0));
            checkOutput("rst_tag",    64'(out_tag),    64'(0));
            n_discard += sb.size();
            sb.delete();
            m_state  = M_IDLE;
            m_rr     = '0;
            acc_mask = '0;
        end else begin
            acc_mask = '0;
            case (m_state)
                M_IDLE: begin
                    checkOutput("idle_valid", 64'(out_valid), 64'(0));
                    checkOutput("idle_busy",  64'(busy),      64'(0));
                    if (|req_valid) begin
                        g       = refGrant(req_valid, m_rr);
                        exp_rdy = N'(1) << g;
                        checkOutput("grant", 64'(req_ready), 64'(exp_rdy));
                        sb.push_back({g, refFloat(req_data[g*22 +: 22])});
                        acc_mask = exp_rdy;
                        m_rr     = (g == TW'(N - 1)) ? '0 : g + TW'(1);
                        m_state  = M_CONV;
                    end else begin
                        checkOutput("idle_ready", 64'(req_ready), 64'(0));
                    end
                end
                M_CONV: begin
                    checkOutput("conv_valid", 64'(out_valid), 64'(0));
                    checkOutput("conv_busy",  64'(busy),      64'(1));
                    checkOutput("conv_ready", 64'(req_ready), 64'(0));
                    m_state = M_HOLD;
                end
                default: begin
                    checkOutput("hold_valid", 64'(out_valid), 64'(1));
                    checkOutput("hold_busy",  64'(busy),      64'(1));
                    checkOutput("hold_ready", 64'(req_ready), 64'(0));
                    if (sb.size() == 0) begin
                        checkOutput("sb_underflow", 64'(1), 64'(0));
                    end else begin
                        head = sb[0];
                        checkOutput("tag",    64'(out_tag),    64'(head[TW+31:32]));
                        checkOutput("result", 64'(out_result), 64'(head[31:0]));
                    end
                    if (out_ready) begin
                        if (sb.size() > 0) sb.delete(0);
                        last_result = out_result;
                        last_tag    = out_tag;
                        otags.push_back(out_tag);
                        n_recv++;
                        m_state = M_IDLE;
                    end
                end
            endcase
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        $display("[TB] directed conversions");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(i % N, vin[i]);
            waitIdle(40);
            checkOutput("vec_result", 64'(last_result), 64'(vexp[i]));
            checkOutput("vec_tag",    64'(last_tag),    64'(i % N));
        end

        $display("[TB] round-robin");
        otags.delete();
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < N; i++) begin
                applyStimulus(i, 22'((i + 1) * 65536 + rep * 7 + 3));
            end
        end
        waitIdle(120);
        checkOutput("rr_count", 64'(otags.size()), 64'(8));
        for (int k = 0; k < 8 && k < otags.size(); k++) begin
            checkOutput("rr_order", 64'(otags[k]), 64'(k % N));
        end

        $display("[TB] backpressure");
        ready_val = 1'b0;
        applyStimulus(1, 22'h155555);
        applyStimulus(2, 22'h2AAAAA);
        waitHold(40);
        repeat (10) @(negedge clk);
        ready_val = 1'b1;
        waitIdle(60);

        $display("[TB] reset during hold");
        ready_val = 1'b0;
        applyStimulus(2, 22'h100000);
        waitHold(40);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async_valid", 64'(out_valid), 64'(0));
        checkOutput("async_busy",  64'(busy),      64'(0));
        applyStimulus(1, 22'h0ABCDE);
        applyStimulus(3, 22'h3FFFFF);
        ready_val = 1'b1;
        otags.delete();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        waitIdle(60);
        checkOutput("post_rst_count", 64'(otags.size()), 64'(2));
        if (otags.size() >= 2) begin
            checkOutput("post_rst_first",  64'(otags[0]), 64'(1));
            checkOutput("post_rst_second", 64'(otags[1]), 64'(3));
        end

        $display("[TB] random soak");
        ready_mode = 1;
        repeat (600) begin
            @(posedge clk);
            #2;
            if ($urandom_range(2) == 0) begin
                int r;
                r = $urandom_range(N - 1);
                if (pend[r].size() < 3) applyStimulus(r, randWord());
            end
        end
        ready_mode = 0;
        ready_val  = 1'b1;
        waitIdle(400);

        checkOutput("sb_left",  64'(sb.size()),            64'(0));
        checkOutput("conserve", 64'(n_recv + n_discard),   64'(n_sent));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fixed_to_float_arbiter.md
Name: fixed_to_float_arbiter

Overview:
- Shares one fixed-to-float normalizer among N_REQ requesters. Each requester presents a 22-bit sign-magnitude fixed-point word (1 sign bit, 1 integer bit, 20 fractional bits).
- Requests are granted round-robin and converted to IEEE-754 single precision. The result is returned on a single valid/ready output port, tagged with the requester index.
- Sits between the fixed-point producers and the float-domain arithmetic units.

Parameters:
- N_REQ, default 4: number of requesters, range 2..16.
- TAG_W, default 2: tag width, equal to $clog2(N_REQ).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_data  in  22*N_REQ  requester i occupies bits [22*i+21 : 22*i]; bit 21 is sign, bits 20:0 are magnitude.
- req_ready  out  N_REQ  one-hot grant/accept; transfer happens when req_valid[i] & req_ready[i].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_result  out  32  IEEE-754 single-precision result.
- out_tag  out  TAG_W  index of the requester that owns out_result.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous on rst_n low):
  - state = IDLE, rr_ptr = 0, out_valid = 0, out_result = 0, out_tag = 0, busy = 0.
  - req_ready = 0 while rst_n is low.
  - Any in-flight operand or result is discarded; no output is produced for it after reset.
- FSM states:
  - IDLE:
    - grant = first i with req_valid[i] set, searching rr_ptr, rr_ptr+1, ... with wrap-around modulo N_REQ.
    - req_ready = onehot(grant), combinational, only in IDLE; req_ready = 0 in all other states.
    - On accept: latch req_data[grant] into operand_q and grant into tag_q, set rr_ptr = grant+1 (mod N_REQ), go to CONV.
    - With no req_valid set, stay in IDLE.
  - CONV: register normalizer output into out_result and tag_q into out_tag; set out_valid = 1; go to HOLD.
  - HOLD:
    - out_valid = 1; out_result and out_tag stay stable until the handshake.
    - On out_ready = 1: clear out_valid and go to IDLE.
    - Otherwise stay in HOLD indefinitely (backpressure).
- Latency and throughput:
  - Accept at edge k gives out_valid = 1 after edge k+1.
  - With out_ready tied high, the next accept occurs at edge k+3. Peak throughput is 1 result per 3 cycles.
- Conversion (magnitude m = bits 20:0, value = m / 2^20):
  - m == 0: result 32'h0000_0000. The sign bit is dropped, so -0 becomes +0.
  - Otherwise, with p = index of the leading one (0..20):
    - exponent = 127 - (20 - p), range 107..127.
    - mantissa = bits below the leading one, left-aligned into 23 bits and zero-filled.
    - sign = bit 21.
  - The conversion is exact (at most 20 fraction bits fit in 23), so there is no rounding, overflow or denormal case.
- Arbitration boundaries:
  - Requesters deasserting req_valid without being granted are legal.
  - A requester's valid seen in IDLE is granted within N_REQ grants, so the scheme is starvation-free.
  - rr_ptr wraps from N_REQ-1 to 0.
  - req_valid changing during CONV or HOLD has no effect.
- Reset mid-HOLD: out_valid falls asynchronously. After release, the first grant begins at requester 0.

Decomposition:
- Package fxfl_pkg:
  - FIXED_W = 22, FRAC_W = 20, FLOAT_W = 32, EXP_BIAS = 127, MANT_W = 23.
  - state enum {IDLE, CONV, HOLD}.
- Sub-module fixed_to_float_norm: purely combinational 22-to-32-bit normalizer containing a priority encoder and barrel shift. It is instantiated once and reused by future converter wrappers.
- The arbiter top holds the FSM, round-robin pointer and output register.

Test Plan:
- Single request: req_valid = 4'b0001, data0 = 22'h100000 (+1.0), out_ready = 1. Expect req_ready[0] for one cycle, then out_valid two edges later with result 32'h3F80_0000 and tag 0.
- Value coverage:
  - 22'h080000 gives 32'h3F00_0000.
  - 22'h300000 (-1.0) gives 32'hBF80_0000.
  - 22'h000001 gives 32'h3580_0000.
  - 22'h200000 (-0) gives 32'h0000_0000.
  - 22'h1FFFFF gives 32'h3FFF_FFF8.
- Round-robin: all four req_valid held high with distinct data. Expect grant order 0, 1, 2, 3, 0, and out_tag following the same sequence.
- Backpressure: out_ready = 0 for 10 cycles after out_valid. Expect out_result and out_tag stable, req_ready = 0 and busy = 1 throughout. Raising out_ready gives one handshake, then the next grant follows in IDLE.
- Reset in HOLD: assert rst_n = 0 mid-HOLD. Expect out_valid = 0 immediately with no clock edge. After release with req_valid = 4'b1010, expect requester 1 granted first.
- Randomized soak: compare each (tag, result) against a reference model and check that no request is lost or duplicated.
